spike_event_logger: RTL and testbench
=====================================

Name: spike_event_logger

Overview:
- Output-side companion to the two-neuron LIF/STDP core: consumes the core's spike and synaptic-weight outputs (n1 spike, n2 spike, 6-bit weight) rather than driving its stimulus.
- Timestamps each spike or weight-change event, buffers events in a small FIFO, and streams them as 4-byte records over a valid/ready byte interface.
- Keeps saturating per-neuron spike counters for on-chip readback.

Parameters:
- FIFO_DEPTH, 8, event records buffered; power of two, >= 2.
- COUNT_WIDTH, 16, width of each spike counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- ena  input  1  capture enable; timestamp and capture frozen when 0
- spike_n1  input  1  neuron 1 spike pulse, one cycle per spike
- spike_n2  input  1  neuron 2 spike pulse
- weight  input  6  current synaptic weight from the core
- out_data  output  8  serialized record byte
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts byte when high with out_valid
- count_n1  output  COUNT_WIDTH  saturating neuron 1 spike count
- count_n2  output  COUNT_WIDTH  saturating neuron 2 spike count
- fifo_level  output  $clog2(FIFO_DEPTH)+1  records held in FIFO
- overflow  output  1  sticky: an event was dropped on full FIFO

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_data=0, counts=0, fifo_level=0, overflow=0.
  - Timestamp ts=0, prev_weight=0, serializer to IDLE.
  - Reset mid-record abandons the record; no partial bytes follow.
- Timestamp:
  - 16-bit ts increments every cycle with ena=1; wraps 0xFFFF->0x0000.
  - An event captures the ts value before that cycle's increment.
- Event detection, ena=1 only:
  - wchg = (weight != prev_weight).
  - prev_weight <= weight every ena cycle.
  - Event when spike_n1 | spike_n2 | wchg.
  - One record per cycle, flags combined on simultaneous events.
  - First cycle after reset with nonzero weight is a wchg event.
- Counters: count_nX += 1 on spike_nX with ena=1; saturate at all-ones with no wrap.
- Record format, bytes sent in order:
  - B0 = {1, spike_n1, spike_n2, wchg, 0000}
  - B1 = {00, weight}
  - B2 = ts[15:8]
  - B3 = ts[7:0]
- FIFO:
  - Push on event.
  - If full and no pop that cycle: drop the event, set overflow (held until rst); counters still update.
  - If full and a pop occurs the same cycle: push is accepted.
  - fifo_level updates the cycle after push/pop.
- Serializer FSM, states IDLE, S0, S1, S2, S3:
  - IDLE: if fifo_level>0, pop head into holding register, go to S0; out_valid=0 in IDLE.
  - Sk: out_valid=1, out_data=Bk.
  - Sk on out_valid & out_ready: advance to S(k+1); from S3 return to IDLE.
  - Back-to-back records therefore have one idle cycle between them.
  - out_data and out_valid hold stable while out_valid & !out_ready.
  - Draining continues regardless of ena.
- Latency:
  - Event at cycle N -> pushed at N+1 -> popped in IDLE at N+1 at the earliest -> B0 valid at N+2 when FIFO was empty and FSM idle.
  - Minimum 5 cycles per record with out_ready held high.

Test Plan:
- Reset values: rst high 3 cycles, weight=0 -> all outputs 0, out_valid=0, ts=0 on release.
- Single spike: after rst release, 10 ena cycles, then spike_n1=1 for one cycle (ts=10), weight=0, out_ready=1 -> bytes 0xC0, 0x00, 0x00, 0x0A, then out_valid=0; count_n1=1.
- Simultaneous events: weight 0->0x15 in the same cycle as spike_n1 and spike_n2 at ts=0x0123 -> B0=0xF0, B1=0x15, B2=0x01, B3=0x23; both counts increment.
- Backpressure: out_ready=0 for 20 cycles during S1 -> out_data=B1 with out_valid=1 held stable; no skipped or duplicated bytes after out_ready=1.
- Overflow: out_ready=0, 12 spikes on spike_n2 in consecutive cycles (FIFO_DEPTH=8) -> fifo_level reaches 8 (one record may already sit in the holding register), overflow=1 and stays 1; drain yields records in order with increasing ts.
- Saturation and wrap: COUNT_WIDTH=4, 20 spike_n1 pulses -> count_n1=15; run ts through 0xFFFF, spike at wrap -> B2=0x00, B3=0x00.

Source files
------------

// File: rtl/spike_event_logger.sv
// spike_event_logger: timestamps LIF/STDP spike and weight-change events, queues them, streams 4-byte records.
// Latency: an event in cycle N is queued at N+1, first byte valid at N+2 when idle; 5 cycles minimum per record.
// Backpressure: bytes hold while out_ready is low; a full queue drops new events and sets sticky overflow.
module spike_event_logger #(
    parameter int FIFO_DEPTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          spike_n1,
    input  logic                          spike_n2,
    input  logic [5:0]                    weight,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COUNT_WIDTH-1:0]        count_n1,
    output logic [COUNT_WIDTH-1:0]        count_n2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 25;  // {n1, n2, wchg, weight[5:0], ts[15:0]}

    typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

    state_t                   state_q, state_d;
    logic [15:0]              ts_q, ts_d;
    logic [5:0]               prev_w_q, prev_w_d;
    logic [COUNT_WIDTH-1:0]   cnt1_q, cnt1_d;
    logic [COUNT_WIDTH-1:0]   cnt2_q, cnt2_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic                     ovf_q, ovf_d;
    logic [RW-1:0]            hold_q, hold_d;
    logic [RW-1:0]            mem_q [FIFO_DEPTH];

    logic                     wchg;
    logic                     evt;
    logic                     full;
    logic                     pop;
    logic                     push;
    logic [RW-1:0]            rec;

    // Event detection, queue bookkeeping, timestamp and counter next-state.
    always_comb begin
        wchg     = (weight != prev_w_q);
        evt      = ena & (spike_n1 | spike_n2 | wchg);
        rec      = {spike_n1, spike_n2, wchg, weight, ts_q};
        full     = (level_q == LW'(FIFO_DEPTH));
        // The serializer pops whenever it is idle with something queued; that
        // pop frees a slot so a same-cycle push on a full queue still fits.
        pop      = (state_q == IDLE) && (level_q != '0);
        push     = evt && (!full || pop);

        ts_d     = ena ? ts_q + 16'd1 : ts_q;
        prev_w_d = ena ? weight : prev_w_q;

        cnt1_d   = cnt1_q;
        if (ena && spike_n1 && (cnt1_q != '1)) begin
            cnt1_d = cnt1_q + COUNT_WIDTH'(1);
        end
        cnt2_d   = cnt2_q;
        if (ena && spike_n2 && (cnt2_q != '1)) begin
            cnt2_d = cnt2_q + COUNT_WIDTH'(1);
        end

        ovf_d    = ovf_q | (evt & ~push);

        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        hold_d   = pop  ? mem_q[rd_ptr_q]   : hold_q;
    end

    // Record storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rec;
        end
    end

    // Datapath and queue state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            prev_w_q <= '0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            ts_q     <= ts_d;
            prev_w_q <= prev_w_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            hold_q   <= hold_d;
        end
    end

    // Serializer state register; reset abandons any record in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Serializer next-state and byte selection from the holding register.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    state_d = S0;
                end
            end
            S0: begin
                out_valid = 1'b1;
                out_data  = {1'b1, hold_q[24], hold_q[23], hold_q[22], 4'b0000};
                if (out_ready) state_d = S1;
            end
            S1: begin
                out_valid = 1'b1;
                out_data  = {2'b00, hold_q[21:16]};
                if (out_ready) state_d = S2;
            end
            S2: begin
                out_valid = 1'b1;
                out_data  = hold_q[15:8];
                if (out_ready) state_d = S3;
            end
            S3: begin
                out_valid = 1'b1;
                out_data  = hold_q[7:0];
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign count_n1   = cnt1_q;
    assign count_n2   = cnt2_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_spike_event_logger.sv
module tb_spike_event_logger;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       spike_n1;
    logic       spike_n2;
    logic [5:0] weight;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count_n1;
    logic [3:0] count_n2;
    logic [3:0] fifo_level;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q [$];
    logic [15:0] ts_exp;
    logic [5:0]  prev_w_exp;

    spike_event_logger #(.FIFO_DEPTH(8), .COUNT_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .spike_n1   (spike_n1),
        .spike_n2   (spike_n2),
        .weight     (weight),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count_n1   (count_n1),
        .count_n2   (count_n2),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any byte handed over this cycle, advance the timestamp
    // model, then step to just after the rising edge.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL byte_unexpected observed=%0h expected=none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("byte", 32'(out_data), 32'(e));
            end
        end
        if (rst) begin
            ts_exp     = 16'h0000;
            prev_w_exp = 6'h00;
        end else if (ena) begin
            ts_exp     = ts_exp + 16'd1;
            prev_w_exp = weight;
        end
        @(posedge clk);
        #1;
    endtask

    // Present one event for one cycle; queue its expected bytes if it will be kept.
    task automatic drive_evt(input logic n1, input logic n2, input logic [5:0] w, input logic keep);
        logic wc;
        spike_n1 = n1;
        spike_n2 = n2;
        weight   = w;
        wc       = (w != prev_w_exp);
        if (keep) begin
            exp_q.push_back({1'b1, n1, n2, wc, 4'b0000});
            exp_q.push_back({2'b00, w});
            exp_q.push_back(ts_exp[15:8]);
            exp_q.push_back(ts_exp[7:0]);
        end
        cyc();
        spike_n1 = 1'b0;
        spike_n2 = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid || fifo_level != 0) && n < 2000) begin
            cyc();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        ena        = 1'b1;
        spike_n1   = 1'b0;
        spike_n2   = 1'b0;
        weight     = 6'h00;
        out_ready  = 1'b1;
        ts_exp     = 16'h0000;
        prev_w_exp = 6'h00;

        // Reset values
        repeat (3) cyc();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_cnt1", 32'(count_n1), 32'd0);
        chk("rst_cnt2", 32'(count_n2), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Single spike at ts=10, with first-byte latency
        repeat (10) cyc();
        chk("ts_before_spike", 32'(ts_exp), 32'd10);
        drive_evt(1'b1, 1'b0, 6'h00, 1'b1);
        chk("lat_level", 32'(fifo_level), 32'd1);
        chk("lat_idle", 32'(out_valid), 32'd0);
        cyc();
        chk("lat_b0_valid", 32'(out_valid), 32'd1);
        chk("lat_b0_data", 32'(out_data), 32'hC0);
        drain("single_drain");
        chk("single_cnt1", 32'(count_n1), 32'd1);
        chk("single_cnt2", 32'(count_n2), 32'd0);

        // Simultaneous spikes and weight change at ts=0x0123
        while (ts_exp != 16'h0123) cyc();
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h23);
        spike_n1 = 1'b1;
        spike_n2 = 1'b1;
        weight   = 6'h15;
        cyc();
        spike_n1 = 1'b0;
        spike_n2 = 1'b0;
        drain("simul_drain");
        chk("simul_cnt1", 32'(count_n1), 32'd2);
        chk("simul_cnt2", 32'(count_n2), 32'd1);

        // Backpressure held in S1 for 20 cycles
        drive_evt(1'b0, 1'b1, 6'h15, 1'b1);
        cyc();
        cyc();
        chk("bp_s1_valid", 32'(out_valid), 32'd1);
        chk("bp_s1_data", 32'(out_data), 32'h15);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'h15);
        end
        out_ready = 1'b1;
        drain("bp_drain");

        // Overflow: 12 back-to-back spikes, sink stalled; one goes to the
        // holding register, eight fill the queue, the rest are dropped
        out_ready = 1'b0;
        chk("ovf_pre", 32'(overflow), 32'd0);
        for (int i = 0; i < 12; i++) begin
            drive_evt(1'b0, 1'b1, 6'h15, (i < 9));
        end
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        repeat (5) cyc();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        drain("ovf_drain");
        chk("ovf_after_drain", 32'(overflow), 32'd1);
        chk("ovf_cnt2", 32'(count_n2), 32'd14);

        // Counter saturation, events spaced so none are dropped
        for (int i = 0; i < 20; i++) begin
            drive_evt(1'b1, (i < 3), 6'h15, 1'b1);
            repeat (5) cyc();
        end
        drain("sat_drain");
        chk("sat_cnt1", 32'(count_n1), 32'd15);
        chk("sat_cnt2", 32'(count_n2), 32'd15);

        // Reset mid-record: no further bytes of the abandoned record
        drive_evt(1'b1, 1'b0, 6'h15, 1'b1);
        cyc();
        cyc();
        exp_q.delete();
        out_ready = 1'b0;
        rst       = 1'b1;
        weight    = 6'h00;
        cyc();
        cyc();
        out_ready = 1'b1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_cnt1", 32'(count_n1), 32'd0);
        rst = 1'b0;
        repeat (8) cyc();
        chk("midrst_quiet", 32'(out_valid), 32'd0);

        // Timestamp wrap: events at 0xFFFF and 0x0000
        while (ts_exp != 16'hFFFF) cyc();
        drive_evt(1'b1, 1'b0, 6'h00, 1'b1);
        chk("wrap_ts_model", 32'(ts_exp), 32'd0);
        drive_evt(1'b1, 1'b0, 6'h00, 1'b1);
        drain("wrap_drain");
        chk("wrap_cnt1", 32'(count_n1), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
